ntt_butterfly_scheduler: RTL

- Sequences the in-place iterative NTT over an N = 2^LOG_N coefficient memory.
- Each cycle it issues one butterfly: read addresses for operands a/b plus a twiddle index, toward the modular arithmetic datapath (modular_adder and multiplier lanes, fixed latency PIPE_LAT).
- It delays those addresses by exactly PIPE_LAT so the datapath results are written back to the same locations.
- It drains the pipeline between stages to avoid read-after-write hazards. It reports busy/done to the top-level controller.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_addr_delay.sv | 47 ++++
 rtl/ntt_butterfly_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the NTT butterfly scheduler.
// Default transform geometry and coefficient format live here.
package ntt_pkg;

    localparam int LOG_N  = 10;
    localparam int N      = 1 << LOG_N;
    localparam int ADDR_W = LOG_N;
    localparam int COEF_W = 30;
    localparam logic [COEF_W-1:0] Q = 30'd998244353;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ntt_addr_delay.sv
// Fixed-depth delay line carrying a valid strobe and two addresses,
// so write-back lines up with the datapath output.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [AW-1:0] addr_b_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_a_o,
    output logic [AW-1:0] addr_b_o
);

    logic          v_q [DEPTH];
    logic [AW-1:0] a_q [DEPTH];
    logic [AW-1:0] b_q [DEPTH];

    // Every slot is cleared so no stale strobe survives a reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            v_q[0] <= valid_i;
            a_q[0] <= addr_a_i;
            b_q[0] <= addr_b_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign valid_o  = v_q[DEPTH-1];
    assign addr_a_o = a_q[DEPTH-1];
    assign addr_b_o = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// Issues one in-place NTT butterfly per cycle, stage by stage, and
// drains the datapath between stages before touching the same words.
module ntt_butterfly_scheduler
    import ntt_pkg::*;
#(
    parameter int LOG_N    = ntt_pkg::LOG_N,
    parameter int PIPE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_valid,
    output logic [LOG_N-1:0]         rd_addr_a,
    output logic [LOG_N-1:0]         rd_addr_b,
    output logic [LOG_N-2:0]         tw_idx,
    output logic                     wr_valid,
    output logic [LOG_N-1:0]         wr_addr_a,
    output logic [LOG_N-1:0]         wr_addr_b,
    output logic [$clog2(LOG_N)-1:0] stage
);

    localparam int KW = LOG_N - 1;
    localparam int SW = $clog2(LOG_N);
    localparam int CW = $clog2(PIPE_LAT + 1);

    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
    localparam logic [CW-1:0] D_LAST = CW'(PIPE_LAT - 1);

    state_e              state_q;
    logic [KW-1:0]       k_q;
    logic [SW-1:0]       stage_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_valid_q;
    logic [LOG_N-1:0]    rd_a_q;
    logic [LOG_N-1:0]    rd_b_q;
    logic [KW-1:0]       tw_q;

    logic [LOG_N-1:0]    half;
    logic [LOG_N-1:0]    jx;
    logic [LOG_N-1:0]    addr_a_d;
    logic [LOG_N-1:0]    addr_b_d;
    logic [KW-1:0]       tw_d;

    always_comb begin
        half     = LOG_N'(1) << stage_q;
        jx       = LOG_N'(k_q) & (half - LOG_N'(1));
        addr_a_d = ((LOG_N'(k_q) >> stage_q)
                    << (32'(stage_q) + 32'd1)) | jx;
        addr_b_d = addr_a_d + half;
        tw_d     = KW'(jx << (LOG_N - 1 - 32'(stage_q)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            stage_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            tw_q       <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    // The cycle showing done still belongs to the finished run.
                    if (start && !done_q) begin
                        state_q <= ST_ISSUE;
                        stage_q <= '0;
                        k_q     <= '0;
                    end
                end
                ST_ISSUE: begin
                    busy_q <= 1'b1;
                    if (!stall) begin
                        rd_valid_q <= 1'b1;
                        rd_a_q     <= addr_a_d;
                        rd_b_q     <= addr_b_d;
                        tw_q       <= tw_d;
                        k_q        <= k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == D_LAST) begin
                        if (stage_q == S_LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            k_q     <= '0;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ntt_addr_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (LOG_N)
    ) u_dly (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (rd_valid_q),
        .addr_a_i (rd_a_q),
        .addr_b_i (rd_b_q),
        .valid_o  (wr_valid),
        .addr_a_o (wr_addr_a),
        .addr_b_o (wr_addr_b)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_idx    = tw_q;
    assign stage     = stage_q;

endmodule
